// File: rtl/ldpc_pkg.sv
// Shared LDPC definitions: decoder FSM states and generator-matrix bit indexing,
// used by both the encoder and the decoder.
package ldpc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYND = 2'd1,
        FLIP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Flat index of P[i][j] (info bit i feeds check j) with m check bits per row.
    function automatic int unsigned p_idx(input int unsigned i, input int unsigned j,
                                          input int unsigned m);
        return i * m + j;
    endfunction

    // Width of an iteration count that can reach max_iter; never below one bit.
    function automatic int unsigned iter_w(input int unsigned max_iter);
        return (max_iter == 0) ? 1 : $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/ldpc_syndrome.sv
// Combinational syndrome of a systematic word: info bits in the upper K positions,
// check bits in the lower N-K positions.
module ldpc_syndrome
    import ldpc_pkg::*;
#(
    parameter int unsigned N = 6,
    parameter int unsigned K = 3
) (
    input  logic [N-1:0]         i_word,
    input  logic [K*(N-K)-1:0]   i_p,
    output logic [N-K-1:0]       o_synd
);

    localparam int unsigned M = N - K;

    always_comb begin
        o_synd = '0;
        for (int j = 0; j < M; j++) begin
            o_synd[j] = i_word[j];
            for (int i = 0; i < K; i++) begin
                o_synd[j] = o_synd[j] ^ (i_word[M + i] & i_p[p_idx(i, j, M)]);
            end
        end
    end

endmodule

// File: rtl/ldpc_decode.sv
// Hard-decision LDPC bit-flip decoder. Define LDPC_BITFLIP_EN for iterative
// flipping; otherwise the block only detects errors and passes raw info through.
module ldpc_decode
    import ldpc_pkg::*;
#(
    parameter int unsigned N        = 6,
    parameter int unsigned K        = 3,
    parameter int unsigned MAX_ITER = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic [N-1:0]                  codeword,
    input  logic [K*(N-K)-1:0]            generator_p,
    output logic                          o_ready,
    output logic                          o_valid,
    output logic [K-1:0]                  info_bits,
    output logic                          o_err,
    output logic [iter_w(MAX_ITER)-1:0]   o_iter
);

    localparam int unsigned M  = N - K;
    localparam int unsigned PW = K * M;
    localparam int unsigned IW = iter_w(MAX_ITER);

    state_t          r_state;
    logic [N-1:0]    r_word;
    logic [PW-1:0]   r_p;
    logic [IW-1:0]   r_cnt;
    logic            r_err_pend;
    logic [M-1:0]    w_synd;

    ldpc_syndrome #(.N(N), .K(K)) u_synd (
        .i_word (r_word),
        .i_p    (r_p),
        .o_synd (w_synd)
    );

`ifdef LDPC_BITFLIP_EN
    localparam int unsigned DW = $clog2(M + 1);

    logic [DW-1:0]   w_deg [N];
    logic [N-1:0]    w_qual;
    logic [N-1:0]    w_flip;
    logic [DW-1:0]   w_max;

    // A bit qualifies when every check it touches fails; flip the highest-degree qualifiers.
    always_comb begin
        w_deg  = '{default: '0};
        w_qual = '0;
        w_flip = '0;
        w_max  = '0;
        for (int j = 0; j < M; j++) begin
            w_deg[j]  = DW'(1);
            w_qual[j] = w_synd[j];
        end
        for (int i = 0; i < K; i++) begin
            w_qual[M + i] = 1'b1;
            for (int j = 0; j < M; j++) begin
                if (r_p[p_idx(i, j, M)]) begin
                    w_deg[M + i] = w_deg[M + i] + DW'(1);
                    if (!w_synd[j]) w_qual[M + i] = 1'b0;
                end
            end
            if (w_deg[M + i] == '0) w_qual[M + i] = 1'b0;
        end
        for (int n = 0; n < N; n++) begin
            if (w_qual[n] && (w_deg[n] > w_max)) w_max = w_deg[n];
        end
        for (int n = 0; n < N; n++) begin
            w_flip[n] = w_qual[n] && (w_deg[n] == w_max);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_p        <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            info_bits  <= '0;
            o_err      <= 1'b0;
            o_iter     <= '0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_en) begin
                        r_word  <= codeword;
                        r_p     <= generator_p;
                        r_cnt   <= '0;
                        o_ready <= 1'b0;
                        r_state <= SYND;
                    end
                end
                SYND: begin
                    if (w_synd == '0) begin
                        r_err_pend <= 1'b0;
                        r_state    <= DONE;
                    end
`ifdef LDPC_BITFLIP_EN
                    else if (r_cnt != IW'(MAX_ITER)) begin
                        r_state <= FLIP;
                    end
`endif
                    else begin
                        r_err_pend <= 1'b1;
                        r_state    <= DONE;
                    end
                end
`ifdef LDPC_BITFLIP_EN
                FLIP: begin
                    r_word  <= r_word ^ w_flip;
                    r_cnt   <= r_cnt + IW'(1);
                    r_state <= SYND;
                end
`endif
                DONE: begin
                    info_bits <= r_word[N-1:M];
                    o_err     <= r_err_pend;
                    o_iter    <= r_cnt;
                    o_valid   <= 1'b1;
                    o_ready   <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_decode.sv
// Scoreboard bench for ldpc_decode: default-depth instance plus a MAX_ITER=0 instance.
module tb_ldpc_decode;

`ifdef LDPC_BITFLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] info;
        logic       err;
        int         iter;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en0 = 1'b0;
    logic       en1 = 1'b0;
    logic [5:0] cw0 = '0;
    logic [5:0] cw1 = '0;
    logic [8:0] gp0 = 9'h1AB;
    logic [8:0] gp1 = 9'h1AB;

    logic       rdy0, vld0, err0;
    logic [2:0] info0;
    logic [3:0] iter0;
    logic       rdy1, vld1, err1;
    logic [2:0] info1;
    logic [0:0] iter1;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    ldpc_decode #(.N(6), .K(3), .MAX_ITER(8)) u_dut0 (
        .clk(clk), .rst(rst), .i_en(en0), .codeword(cw0), .generator_p(gp0),
        .o_ready(rdy0), .o_valid(vld0), .info_bits(info0), .o_err(err0), .o_iter(iter0)
    );

    ldpc_decode #(.N(6), .K(3), .MAX_ITER(0)) u_dut1 (
        .clk(clk), .rst(rst), .i_en(en1), .codeword(cw1), .generator_p(gp1),
        .o_ready(rdy1), .o_valid(vld1), .info_bits(info1), .o_err(err1), .o_iter(iter1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every result strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (vld0) begin
            if (q0.size() == 0) begin
                chk("dut0 unexpected o_valid", 32'(vld0), 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("dut0 latency", 32'(cyc), 32'(e0.cyc));
                chk("dut0 info_bits", 32'(info0), 32'(e0.info));
                chk("dut0 o_err", 32'(err0), 32'(e0.err));
                chk("dut0 o_iter", 32'(iter0), 32'(e0.iter));
            end
        end
    end

    always @(negedge clk) begin
        if (vld1) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected o_valid", 32'(vld1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("dut1 latency", 32'(cyc), 32'(e1.cyc));
                chk("dut1 info_bits", 32'(info1), 32'(e1.info));
                chk("dut1 o_err", 32'(err1), 32'(e1.err));
                chk("dut1 o_iter", 32'(iter1), 32'(e1.iter));
            end
        end
    end

    // Drive a start that is accepted at the very next rising edge.
    task automatic accept0(input logic [5:0] cw, input logic [2:0] info, input logic err,
                           input int iter, input int lat, input bit hold);
        cw0 = cw;
        en0 = 1'b1;
        @(posedge clk); #1;
        q0.push_back('{info: info, err: err, iter: iter, cyc: cyc + lat});
        if (!hold) en0 = 1'b0;
        chk("dut0 busy after accept", 32'(rdy0), 32'd0);
    endtask

    task automatic issue0(input logic [5:0] cw, input logic [2:0] info, input logic err,
                          input int iter, input int lat, input bit hold);
        @(negedge clk);
        chk("dut0 ready before accept", 32'(rdy0), 32'd1);
        accept0(cw, info, err, iter, lat, hold);
    endtask

    task automatic issue1(input logic [5:0] cw, input logic [2:0] info, input logic err);
        @(negedge clk);
        chk("dut1 ready before accept", 32'(rdy1), 32'd1);
        cw1 = cw;
        en1 = 1'b1;
        @(posedge clk); #1;
        q1.push_back('{info: info, err: err, iter: 0, cyc: cyc + 2});
        en1 = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Flip-build vs detect-only expectations for the single-error and oscillating words.
    localparam logic [2:0] INF_05 = FLIP_EN ? 3'b010 : 3'b000;
    localparam logic [2:0] INF_03 = FLIP_EN ? 3'b001 : 3'b000;
    localparam logic       ERR_1F = FLIP_EN ? 1'b0 : 1'b1;
    localparam int         IT_1F  = FLIP_EN ? 1 : 0;
    localparam int         LAT_1F = FLIP_EN ? 4 : 2;
    localparam int         IT_12  = FLIP_EN ? 8 : 0;
    localparam int         LAT_12 = FLIP_EN ? 18 : 2;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset o_ready", 32'(rdy0), 32'd1);
        chk("reset o_valid", 32'(vld0), 32'd0);
        chk("reset info_bits", 32'(info0), 32'd0);
        chk("reset o_err", 32'(err0), 32'd0);
        chk("reset o_iter", 32'(iter0), 32'd0);

        // First accept on the first rising edge after reset release.
        @(negedge clk);
        rst = 1'b0;
        accept0(6'h15, 3'b010, 1'b0, 0, 2, 1'b0);
        repeat (2) @(posedge clk);

        issue0(6'h17, 3'b010, ERR_1F, IT_1F, LAT_1F, 1'b0);
        repeat (LAT_1F) @(posedge clk);

        // Generator change after accept must not disturb the decode.
        issue0(6'h05, INF_05, ERR_1F, IT_1F, LAT_1F, 1'b0);
        gp0 = 9'h000;
        repeat (LAT_1F) @(posedge clk);
        gp0 = 9'h1AB;

        issue0(6'h03, INF_03, ERR_1F, IT_1F, LAT_1F, 1'b0);
        repeat (LAT_1F) @(posedge clk);

        issue0(6'h0B, 3'b001, 1'b0, 0, 2, 1'b0);
        repeat (2) @(posedge clk);

        // Oscillating word; a start request while busy must be ignored.
        issue0(6'h12, 3'b010, 1'b1, IT_12, LAT_12, 1'b0);
        @(negedge clk);
        cw0 = 6'h15;
        en0 = 1'b1;
        @(negedge clk);
        en0 = 1'b0;
        repeat (LAT_12) @(posedge clk);

        // i_en held high with a mid-decode word change: the second decode starts only from IDLE.
        issue0(6'h17, 3'b010, ERR_1F, IT_1F, LAT_1F, 1'b1);
        cw0 = 6'h05;
        repeat (LAT_1F + 1) @(posedge clk);
        #1;
        q0.push_back('{info: INF_05, err: ERR_1F, iter: IT_1F, cyc: cyc + LAT_1F});
        en0 = 1'b0;
        repeat (LAT_1F) @(posedge clk);

        // Reset during the flip phase aborts silently and clears everything.
        @(negedge clk);
        cw0 = 6'h17;
        en0 = 1'b1;
        @(posedge clk); #1;
        en0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-reset o_ready", 32'(rdy0), 32'd1);
        chk("mid-reset o_valid", 32'(vld0), 32'd0);
        chk("mid-reset info_bits", 32'(info0), 32'd0);
        chk("mid-reset o_err", 32'(err0), 32'd0);
        chk("mid-reset o_iter", 32'(iter0), 32'd0);
        rst = 1'b0;
        accept0(6'h17, 3'b010, ERR_1F, IT_1F, LAT_1F, 1'b0);
        repeat (LAT_1F) @(posedge clk);

        // Zero iteration cap: any nonzero syndrome is reported immediately.
        issue1(6'h17, 3'b010, 1'b1);
        issue1(6'h15, 3'b010, 1'b0);
        issue1(6'h12, 3'b010, 1'b1);
        issue1(6'h05, 3'b000, 1'b1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("dut0 outstanding results", 32'(q0.size()), 32'd0);
        chk("dut1 outstanding results", 32'(q1.size()), 32'd0);
        chk("dut0 final info hold", 32'(info0), 32'(3'b010));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
